// File: rtl/exe_stage_pipe.sv
// rtl/exe_stage_pipe.sv - registered RISC-V execute stage with forwarding, handshake and flush
// Optional iterative shift-add multiplier is built when EXE_MUL_EN is defined.
module exe_stage_pipe #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [3:0]      func,
    input  logic            in_mul,
    input  logic            use_imm,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic [XLEN-1:0] wb_fwd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_t;

    state_t          state, state_next;
    op_t             op;
    logic [XLEN-1:0] op_a, op_b, b_neg, b_add, sum, alu_res;
    logic [SHW-1:0]  shamt;
    logic            alu_ovf;
    logic            accept;
    logic            is_mul;

    always_comb begin
        op_a = rs1_data;
        case (fwd_a_sel)
            2'b01:   op_a = mem_fwd;
            2'b10:   op_a = wb_fwd;
            default: op_a = rs1_data;
        endcase
        op_b = rs2_data;
        if (use_imm) begin
            op_b = imm;
        end else begin
            case (fwd_b_sel)
                2'b01:   op_b = mem_fwd;
                2'b10:   op_b = wb_fwd;
                default: op_b = rs2_data;
            endcase
        end
    end

    // I-type only honours func[3] for the shift-right pair, so it never decodes SUB
    always_comb begin
        op = OP_ADD;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            default: begin
                case (func[2:0])
                    3'b000:  op = (alu_op == 2'b10 && func[3]) ? OP_SUB : OP_ADD;
                    3'b001:  op = OP_SLL;
                    3'b010:  op = OP_SLT;
                    3'b011:  op = OP_SLTU;
                    3'b100:  op = OP_XOR;
                    3'b101:  op = func[3] ? OP_SRA : OP_SRL;
                    3'b110:  op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        b_neg   = ~op_b + XLEN'(1);
        b_add   = (op == OP_SUB) ? b_neg : op_b;
        sum     = op_a + b_add;
        shamt   = op_b[SHW-1:0];
        alu_res = sum;
        case (op)
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            default: alu_res = sum;
        endcase
        alu_ovf = ((op == OP_ADD) || (op == OP_SUB)) &&
                  (op_a[XLEN-1] == b_add[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
    end

    assign in_ready = rst_n && (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

`ifdef EXE_MUL_EN
    logic [XLEN-1:0] mul_a, mul_b, mul_acc;
    logic [SHW:0]    mul_cnt;
    logic            mul_load;

    assign is_mul   = (alu_op == 2'b10) && in_mul && (func[2:0] == 3'b000);
    assign mul_load = (state == S_DONE) && (!out_valid || out_ready);

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept && is_mul) state_next = S_MUL;
                S_MUL:   if (mul_cnt == (SHW+1)'(1)) state_next = S_DONE;
                S_DONE:  if (!out_valid || out_ready) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else if (accept && is_mul) begin
            mul_a   <= op_a;
            mul_b   <= op_b;
            mul_acc <= '0;
            mul_cnt <= (SHW+1)'(XLEN);
        end else if (state == S_MUL) begin
            if (mul_b[0]) mul_acc <= mul_acc + mul_a;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt - (SHW+1)'(1);
        end
    end
`else
    logic unused_in_mul;
    assign unused_in_mul = in_mul;
    assign is_mul        = 1'b0;

    always_comb begin
        state_next = S_IDLE;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !is_mul) begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
            out_valid <= 1'b1;
`ifdef EXE_MUL_EN
        end else if (mul_load) begin
            result    <= mul_acc;
            zero      <= (mul_acc == '0);
            overflow  <= 1'b0;
            out_valid <= 1'b1;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
